// File: rtl/lockin_frame_fifo.sv
// Lock-in capture buffer: latches NUM_CH (x, y) pairs plus a 32-bit sample counter per tick
// into a first-word-fall-through frame FIFO. Optional block averaging: define LOCKIN_FIFO_DECIM_EN.
module lockin_frame_fifo #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LOG2_DECIM = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       tick_i,
    input  logic [NUM_CH*DATA_W-1:0]   x_i,
    input  logic [NUM_CH*DATA_W-1:0]   y_i,
    input  logic                       enable_i,
    input  logic                       clear_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [NUM_CH*DATA_W-1:0]   rd_x_o,
    output logic [NUM_CH*DATA_W-1:0]   rd_y_o,
    output logic [31:0]                rd_count_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned VW = NUM_CH * DATA_W;

    if (DEPTH < 2 || (1 << AW) != DEPTH || LOG2_DECIM > 16) begin : g_param_check
        $error("lockin_frame_fifo: DEPTH must be a power of 2 >= 2 and LOG2_DECIM <= 16");
    end

    logic [VW-1:0]  r_mem_x [DEPTH];
    logic [VW-1:0]  r_mem_y [DEPTH];
    logic [31:0]    r_mem_c [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;
    logic [31:0]    r_cnt;
    logic           r_ovf;
    logic [15:0]    r_drop;

    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_wr;
    logic           w_drop;
    logic [VW-1:0]  w_frame_x;
    logic [VW-1:0]  w_frame_y;

    assign w_accept = tick_i && enable_i && !clear_i;

`ifdef LOCKIN_FIFO_DECIM_EN
    localparam int unsigned ACC_W = DATA_W + LOG2_DECIM;

    logic signed [ACC_W-1:0]      r_acc_x [NUM_CH];
    logic signed [ACC_W-1:0]      r_acc_y [NUM_CH];
    logic        [LOG2_DECIM-1:0] r_phase;
    logic signed [ACC_W-1:0]      w_sum_x [NUM_CH];
    logic signed [ACC_W-1:0]      w_sum_y [NUM_CH];
    logic                         w_last;

    assign w_last = (r_phase == '1);
    assign w_push = w_accept && w_last;

    // The final tick of a block is folded into the sum combinationally so the frame
    // is pushed on that same tick; the arithmetic shift truncates toward -inf.
    always_comb begin
        w_frame_x = '0;
        w_frame_y = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_sum_x[k] = r_acc_x[k] + ACC_W'(signed'(x_i[k*DATA_W +: DATA_W]));
            w_sum_y[k] = r_acc_y[k] + ACC_W'(signed'(y_i[k*DATA_W +: DATA_W]));
            w_frame_x[k*DATA_W +: DATA_W] = DATA_W'(w_sum_x[k] >>> LOG2_DECIM);
            w_frame_y[k*DATA_W +: DATA_W] = DATA_W'(w_sum_y[k] >>> LOG2_DECIM);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_phase <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_acc_x[k] <= '0;
                r_acc_y[k] <= '0;
            end
        end else if (clear_i) begin
            r_phase <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_acc_x[k] <= '0;
                r_acc_y[k] <= '0;
            end
        end else if (w_accept) begin
            r_phase <= r_phase + 1'b1;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                r_acc_x[k] <= w_last ? '0 : w_sum_x[k];
                r_acc_y[k] <= w_last ? '0 : w_sum_y[k];
            end
        end
    end
`else
    assign w_push    = w_accept;
    assign w_frame_x = x_i;
    assign w_frame_y = y_i;
`endif

    assign w_full = (r_level == (AW+1)'(DEPTH));
    assign w_pop  = rd_valid_o && rd_ready_i;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem_x[r_wr_ptr] <= w_frame_x;
            r_mem_y[r_wr_ptr] <= w_frame_y;
            r_mem_c[r_wr_ptr] <= r_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_accept) r_cnt    <= r_cnt + 32'd1;
            if (w_wr)     r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + 16'd1;
            end
        end
    end

    // Head data is gated so an empty FIFO reads zero, including straight out of reset.
    assign rd_valid_o   = (r_level != '0);
    assign rd_x_o       = rd_valid_o ? r_mem_x[r_rd_ptr] : '0;
    assign rd_y_o       = rd_valid_o ? r_mem_y[r_rd_ptr] : '0;
    assign rd_count_o   = rd_valid_o ? r_mem_c[r_rd_ptr] : '0;
    assign level_o      = r_level;
    assign overflow_o   = r_ovf;
    assign drop_count_o = r_drop;

endmodule
